// File: rtl/calc_pkg.sv
// Shared types for the keypad-to-arithmetic operand path.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package calc_pkg;

  localparam int CALC_DATA_W = 16;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_NEG  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ISSUE   = 2'd2
  } asm_state_t;

  // True for operator codes that take two operands (add, sub, mul).
  function automatic logic is_binary_op(input logic [2:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
  endfunction

endpackage

// File: rtl/digit_accumulator.sv
// Decimal entry register: magnitude, sign and digit count of the operand being typed.
// Latency: one cycle from a digit/negate/clear strobe to the updated value_o.
// Backpressure: none; a digit that would exceed MAX_MAG is dropped and flagged on reject_o.
module digit_accumulator
  import calc_pkg::*;
#(
  parameter int DATA_W  = CALC_DATA_W,
  parameter int MAX_MAG = 32767
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              digit_vld_i,
  input  logic [3:0]        digit_i,
  input  logic              negate_i,
  output logic [DATA_W-1:0] value_o,
  output logic              reject_o,
  output logic [2:0]        count_o
);

  // Four extra bits hold mag*10+9 for any DATA_W-bit magnitude.
  localparam int WIDE_W = DATA_W + 4;

  logic [DATA_W-1:0] mag_q, mag_d;
  logic              sign_q, sign_d;
  logic [2:0]        count_q, count_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              reject_q, reject_d;
  logic [WIDE_W-1:0] wide_mag;

  // Next-state: clear wins, otherwise fold in the digit and/or toggle the sign.
  always_comb begin
    wide_mag = WIDE_W'(mag_q) * WIDE_W'(10) + WIDE_W'(digit_i);
    mag_d    = mag_q;
    sign_d   = sign_q;
    count_d  = count_q;
    reject_d = 1'b0;
    if (clear_i) begin
      mag_d   = '0;
      sign_d  = 1'b0;
      count_d = '0;
    end else begin
      if (digit_vld_i) begin
        if (wide_mag > WIDE_W'(MAX_MAG)) begin
          reject_d = 1'b1;
        end else begin
          mag_d = wide_mag[DATA_W-1:0];
          if (count_q != 3'd7) count_d = count_q + 3'd1;
        end
      end
      if (negate_i) sign_d = ~sign_q;
    end
    // Negating a zero magnitude yields zero, so -0 displays as 0.
    value_d = sign_d ? (-mag_d) : mag_d;
  end

  // Entry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q    <= '0;
      sign_q   <= 1'b0;
      count_q  <= '0;
      value_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      mag_q    <= mag_d;
      sign_q   <= sign_d;
      count_q  <= count_d;
      value_q  <= value_d;
      reject_q <= reject_d;
    end
  end

  assign value_o  = value_q;
  assign reject_o = reject_q;
  assign count_o  = count_q;

endmodule

// File: rtl/key_operand_assembler.sv
// Assembles keypad events into operands/operator and issues a calc request (KEY_OPERAND_CHAIN_EN adds result chaining).
// Latency: key_read one cycle after read_input is seen; calc_valid one cycle after the equal key is accepted.
// Backpressure: calc_valid holds with stable operands until calc_ready; keys wait un-acknowledged meanwhile.
module key_operand_assembler
  import calc_pkg::*;
#(
  parameter int DATA_W  = CALC_DATA_W,
  parameter int MAX_MAG = 32767
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              read_input,
  input  logic [3:0]        keypad_input,
  input  logic [2:0]        operator_input,
  input  logic              equal_input,
  output logic              key_read,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        op_sel,
  output logic              calc_valid,
  input  logic              calc_ready,
`ifdef KEY_OPERAND_CHAIN_EN
  input  logic [DATA_W-1:0] result_in,
`endif
  output logic [DATA_W-1:0] entry_value,
  output logic              digit_reject
);

  asm_state_t        state_q, state_d;
  logic              armed_q, armed_d;
  logic              key_read_q;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [2:0]        op_sel_q, op_sel_d;

  logic              accept;
  logic              key_is_bin;
  logic              acc_clear, acc_digit, acc_neg;
  logic [2:0]        acc_count;
  logic [DATA_W-1:0] acc_value;

  digit_accumulator #(
    .DATA_W  (DATA_W),
    .MAX_MAG (MAX_MAG)
  ) u_acc (
    .clk         (clk),
    .rst         (RST),
    .clear_i     (acc_clear),
    .digit_vld_i (acc_digit),
    .digit_i     (keypad_input),
    .negate_i    (acc_neg),
    .value_o     (acc_value),
    .reject_o    (digit_reject),
    .count_o     (acc_count)
  );

  // Key decode and next-state: equal beats operator beats digit.
  always_comb begin
    accept     = read_input && armed_q && (state_q != ISSUE);
    key_is_bin = !equal_input && is_binary_op(operator_input);
    acc_digit  = accept && !equal_input && (operator_input == OP_NONE) && (keypad_input <= 4'd9);
    acc_neg    = accept && !equal_input && (operator_input == OP_NEG);
    acc_clear  = 1'b0;
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    // A held key is consumed once; re-arm only after read_input drops.
    armed_d    = accept ? 1'b0 : (!read_input ? 1'b1 : armed_q);
    case (state_q)
      ENTER_A: begin
        if (accept && key_is_bin) begin
          op_a_d    = acc_value;
          op_sel_d  = operator_input;
          acc_clear = 1'b1;
          state_d   = ENTER_B;
        end
      end
      ENTER_B: begin
        if (accept && equal_input && (acc_count != 3'd0)) begin
          op_b_d  = acc_value;
          state_d = ISSUE;
        end else if (accept && key_is_bin && (acc_count == 3'd0)) begin
          op_sel_d = operator_input;
        end
      end
      ISSUE: begin
        if (calc_ready) begin
          acc_clear = 1'b1;
`ifdef KEY_OPERAND_CHAIN_EN
          op_a_d  = result_in;
          state_d = ENTER_B;
`else
          op_a_d  = '0;
          op_b_d  = '0;
          state_d = ENTER_A;
`endif
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  // State, handshake and latched operand registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= ENTER_A;
      armed_q    <= 1'b1;
      key_read_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sel_q   <= OP_ADD;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      key_read_q <= accept;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
    end
  end

  assign key_read    = key_read_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_sel      = op_sel_q;
  assign calc_valid  = (state_q == ISSUE);
  assign entry_value = acc_value;

endmodule

// File: tb/tb_key_operand_assembler.sv
// Directed bench for key_operand_assembler with a scoreboard of expected calc requests.
// Latency: drives on falling edges, samples on falling edges (away from the rising active edge).
// Backpressure: exercises calc_ready held low in ISSUE while a key is pending.
module tb_key_operand_assembler;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        RST;
  logic        read_input;
  logic [3:0]  keypad_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        key_read;
  logic [15:0] op_a, op_b, entry_value;
  logic [2:0]  op_sel;
  logic        calc_valid, calc_ready, digit_reject;
  logic [15:0] result_in;

  int   total  = 0;
  int   passed = 0;
  int   failed = 0;
  logic last_rej;
  exp_t sb_q[$];

  key_operand_assembler #(.DATA_W(16), .MAX_MAG(32767)) dut (
    .clk            (clk),
    .RST            (RST),
    .read_input     (read_input),
    .keypad_input   (keypad_input),
    .operator_input (operator_input),
    .equal_input    (equal_input),
    .key_read       (key_read),
    .op_a           (op_a),
    .op_b           (op_b),
    .op_sel         (op_sel),
    .calc_valid     (calc_valid),
    .calc_ready     (calc_ready),
`ifdef KEY_OPERAND_CHAIN_EN
    .result_in      (result_in),
`endif
    .entry_value    (entry_value),
    .digit_reject   (digit_reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One key press held 5 cycles, then 2 idle cycles; exactly one key_read expected.
  task automatic press(input logic eq, input logic [2:0] op, input logic [3:0] d, input string tag);
    int n;
    n = 0;
    last_rej = 1'b0;
    equal_input = eq; operator_input = op; keypad_input = d; read_input = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        read_input = 1'b0; equal_input = 1'b0; operator_input = 3'b000; keypad_input = 4'd0;
      end
      @(negedge clk);
      if (key_read) n++;
      if (digit_reject) last_rej = 1'b1;
    end
    check({tag, "_key_read_count"}, n, 1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
  endtask

  // Compare the pending request against the scoreboard head, then accept it.
  task automatic transfer(input string tag, input logic [15:0] res);
    exp_t e;
    int   k;
    k = 0;
    while (!calc_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_calc_valid"}, calc_valid, 1);
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_op_a"}, op_a, e.a);
      check({tag, "_op_b"}, op_b, e.b);
      check({tag, "_op_sel"}, op_sel, e.sel);
    end
    result_in  = res;
    calc_ready = 1'b1;
    @(negedge clk);
    calc_ready = 1'b0;
    check({tag, "_calc_valid_drop"}, calc_valid, 0);
    check({tag, "_entry_cleared"}, entry_value, 0);
`ifdef KEY_OPERAND_CHAIN_EN
    check({tag, "_op_a_chained"}, op_a, res);
`else
    check({tag, "_op_a_cleared"}, op_a, 0);
    check({tag, "_op_b_cleared"}, op_b, 0);
`endif
  endtask

  initial begin
    logic kr_seen, cv_drop;
    int   n;
    RST = 1'b1; read_input = 1'b0; keypad_input = 4'd0; operator_input = 3'b000;
    equal_input = 1'b0; calc_ready = 1'b0; result_in = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_key_read", key_read, 0);
    check("rst_calc_valid", calc_valid, 0);
    check("rst_digit_reject", digit_reject, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_entry", entry_value, 0);
    check("rst_op_sel", op_sel, 3'b010);
    RST = 1'b0;
    @(negedge clk);

    // 123 + 45
    press(0, 3'b000, 4'd1, "t1_d1");
    press(0, 3'b000, 4'd2, "t1_d2");
    press(0, 3'b000, 4'd3, "t1_d3");
    check("t1_entry_123", entry_value, 16'd123);
    press(0, 3'b010, 4'd0, "t1_add");
    check("t1_op_a_latched", op_a, 16'd123);
    press(0, 3'b000, 4'd4, "t1_d4");
    press(0, 3'b000, 4'd5, "t1_d5");
    sb_q.push_back('{a: 16'd123, b: 16'd45, sel: 3'b010});
    press(1, 3'b000, 4'd0, "t1_eq");
    transfer("t1", 16'd168);
`ifdef KEY_OPERAND_CHAIN_EN
    // Chained: already in ENTER_B, so a digit plus equal issues 168 op 2.
    press(0, 3'b000, 4'd2, "tc_d2");
    sb_q.push_back('{a: 16'd168, b: 16'd2, sel: 3'b010});
    press(1, 3'b000, 4'd0, "tc_eq");
    transfer("tc", 16'd0);
`endif

    // Overflow boundary at 32767.
    do_reset();
    press(0, 3'b000, 4'd3, "t2_d3");
    press(0, 3'b000, 4'd2, "t2_d2");
    press(0, 3'b000, 4'd7, "t2_d7");
    press(0, 3'b000, 4'd6, "t2_d6");
    press(0, 3'b000, 4'd7, "t2_d7b");
    check("t2_no_reject_on_7", last_rej, 0);
    check("t2_entry_32767", entry_value, 16'd32767);
    press(0, 3'b000, 4'd8, "t2_d8");
    check("t2_reject_on_8", last_rej, 1);
    check("t2_entry_held", entry_value, 16'd32767);
    press(0, 3'b000, 4'd12, "t2_d12");
    check("t2_entry_after_bad_digit", entry_value, 16'd32767);

    // Negatives: -5 * -9
    do_reset();
    press(0, 3'b000, 4'd5, "t3_d5");
    press(0, 3'b001, 4'd0, "t3_neg");
    check("t3_entry_neg5", entry_value, 16'hFFFB);
    press(0, 3'b100, 4'd0, "t3_mul");
    press(0, 3'b001, 4'd0, "t3_neg0");
    check("t3_entry_neg_zero", entry_value, 16'd0);
    press(0, 3'b000, 4'd9, "t3_d9");
    check("t3_entry_neg9", entry_value, 16'hFFF7);
    sb_q.push_back('{a: 16'hFFFB, b: 16'hFFF7, sel: 3'b100});
    press(1, 3'b000, 4'd0, "t3_eq");
    transfer("t3", 16'd45);

    // Operator replacement rules and ignored equal in ENTER_B.
    do_reset();
    press(0, 3'b000, 4'd1, "t4_d1");
    press(0, 3'b010, 4'd0, "t4_add");
    press(0, 3'b011, 4'd0, "t4_sub");
    check("t4_op_sel_replaced", op_sel, 3'b011);
    press(1, 3'b000, 4'd0, "t4_eq_empty");
    check("t4_no_calc_valid", calc_valid, 0);
    press(0, 3'b000, 4'd2, "t4_d2");
    press(0, 3'b100, 4'd0, "t4_mul_late");
    check("t4_op_sel_kept", op_sel, 3'b011);
    sb_q.push_back('{a: 16'd1, b: 16'd2, sel: 3'b011});
    press(1, 3'b000, 4'd0, "t4_eq");

    // Key pending during ISSUE waits for the transfer.
    keypad_input = 4'd7; read_input = 1'b1;
    kr_seen = 1'b0; cv_drop = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (key_read) kr_seen = 1'b1;
      if (!calc_valid) cv_drop = 1'b1;
    end
    check("t5_key_read_blocked", kr_seen, 0);
    check("t5_calc_valid_held", cv_drop, 0);
    transfer("t5", 16'd3);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        read_input = 1'b0; keypad_input = 4'd0;
      end
      @(negedge clk);
      if (key_read) n++;
    end
    check("t5_key_read_after", n, 1);
    check("t5_entry_7", entry_value, 16'd7);

    // Reset while a request is pending.
    do_reset();
    press(0, 3'b000, 4'd4, "t6_d4");
    press(0, 3'b010, 4'd0, "t6_add");
    press(0, 3'b000, 4'd6, "t6_d6");
    press(1, 3'b000, 4'd0, "t6_eq");
    check("t6_calc_valid_before", calc_valid, 1);
    #2 RST = 1'b1;
    #1;
    check("t6_rst_calc_valid", calc_valid, 0);
    check("t6_rst_op_a", op_a, 0);
    check("t6_rst_op_b", op_b, 0);
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
